// File: rtl/mul2_norm_round.sv
// Second half of the two-stage FP multiplier: forms the mantissa product (P stage), then
// normalizes, rounds to nearest-even and packs the IEEE result with flags (R stage).
module mul2_norm_round #(
    parameter  int unsigned SIGN_W = 1,
    parameter  int unsigned EXPO_W = 8,
    parameter  int unsigned MANT_W = 23,
    localparam int unsigned ZERO_D = $clog2(MANT_W + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SIGN_W-1:0]                sign_1,
    input  logic [EXPO_W+1:0]                expo_1,
    input  logic [MANT_W:0]                  a_mant_f,
    input  logic [MANT_W:0]                  b_mant_f,
    input  logic [ZERO_D:0]                  r_shift,
    input  logic [ZERO_D:0]                  l_shift,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0]  res,
    output logic                             ovf,
    output logic                             unf,
    output logic                             inx
);

    localparam int unsigned PW = 2 * MANT_W + 2;
    localparam int unsigned EW = EXPO_W + 4;
    localparam int unsigned RW = SIGN_W + EXPO_W + MANT_W;

    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXPO_W) - 1);

    // Handshake
    logic p_valid_q;
    logic out_valid_q;
    logic r_adv;
    logic p_adv;
    logic p_load;

    assign r_adv     = ~out_valid_q | out_ready;
    assign p_adv     = ~p_valid_q | r_adv;
    assign in_ready  = p_adv;
    assign p_load    = in_valid & p_adv;
    assign out_valid = out_valid_q;

    // P stage
    logic [PW-1:0]             prod_d;
    logic [PW-1:0]             prod_q;
    logic [SIGN_W-1:0]         sign_q;
    logic signed [EXPO_W+1:0]  expo_q;
    logic [ZERO_D:0]           r_shift_q;
    logic [ZERO_D:0]           l_shift_q;

    assign prod_d = PW'(a_mant_f) * PW'(b_mant_f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q <= 1'b0;
            prod_q    <= '0;
            sign_q    <= '0;
            expo_q    <= '0;
            r_shift_q <= '0;
            l_shift_q <= '0;
        end else begin
            if (p_adv) begin
                p_valid_q <= in_valid;
            end
            if (p_load) begin
                prod_q    <= prod_d;
                sign_q    <= sign_1;
                expo_q    <= expo_1;
                r_shift_q <= r_shift;
                l_shift_q <= l_shift;
            end
        end
    end

    // R stage datapath: align, normalize, round
    logic [PW-1:0]          sh_mask;
    logic [PW-1:0]          p_aligned;
    logic                   r_sticky;
    logic signed [EW-1:0]   e_pre;
    logic signed [EW-1:0]   e_norm;
    logic signed [EW-1:0]   e_fin;
    logic [MANT_W-1:0]      m_trunc;
    logic [MANT_W-1:0]      m_fin;
    logic [MANT_W:0]        m_sum;
    logic                   g_bit;
    logic                   st_bit;
    logic                   round_up;
    logic                   inexact;

    always_comb begin
        sh_mask   = ~({PW{1'b1}} << r_shift_q);
        r_sticky  = 1'b0;
        p_aligned = prod_q;
        e_pre     = EW'(expo_q);
        // A subnormal result shift wins over a subnormal operand shift.
        if (r_shift_q != '0) begin
            p_aligned = prod_q >> r_shift_q;
            r_sticky  = |(prod_q & sh_mask);
            e_pre     = E_ZERO;
        end else if (l_shift_q != '0) begin
            p_aligned = prod_q << l_shift_q;
            e_pre     = EW'(expo_q) - EW'(l_shift_q);
        end

        if (p_aligned[PW-1]) begin
            m_trunc = p_aligned[PW-2 -: MANT_W];
            g_bit   = p_aligned[MANT_W];
            st_bit  = |p_aligned[MANT_W-1:0];
            e_norm  = e_pre + E_ONE;
        end else begin
            m_trunc = p_aligned[PW-3 -: MANT_W];
            g_bit   = p_aligned[MANT_W-1];
            st_bit  = |p_aligned[MANT_W-2:0];
            e_norm  = e_pre;
        end

        round_up = g_bit & (st_bit | m_trunc[0]);
        m_sum    = {1'b0, m_trunc} + {{MANT_W{1'b0}}, round_up};
        // Fraction carry-out means the significand rounded up to the next power of two.
        if (m_sum[MANT_W]) begin
            m_fin = '0;
            e_fin = e_norm + E_ONE;
        end else begin
            m_fin = m_sum[MANT_W-1:0];
            e_fin = e_norm;
        end
        inexact = g_bit | st_bit | r_sticky;
    end

    // R stage packing and exceptions
    logic [RW-1:0] res_d;
    logic          ovf_d;
    logic          unf_d;
    logic          inx_d;

    always_comb begin
        res_d = {sign_q, EXPO_W'(0), MANT_W'(0)};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        if (prod_q == '0) begin
            res_d = {sign_q, EXPO_W'(0), MANT_W'(0)};
        end else if (e_fin >= E_MAX) begin
            res_d = {sign_q, {EXPO_W{1'b1}}, MANT_W'(0)};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (e_fin <= E_ZERO) begin
            if (r_shift_q != '0) begin
                res_d = {sign_q, EXPO_W'(0), m_fin};
                unf_d = inexact;
                inx_d = inexact;
            end else begin
                res_d = {sign_q, EXPO_W'(0), MANT_W'(0)};
                unf_d = 1'b1;
                inx_d = 1'b1;
            end
        end else begin
            res_d = {sign_q, e_fin[EXPO_W-1:0], m_fin};
            inx_d = inexact;
        end
    end

    logic [RW-1:0] res_q;
    logic          ovf_q;
    logic          unf_q;
    logic          inx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (r_adv) begin
            out_valid_q <= p_valid_q;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign res = res_q;
    assign ovf = ovf_q;
    assign unf = unf_q;
    assign inx = inx_q;

endmodule

// File: tb/tb_mul2_norm_round.sv
// Scoreboard bench for mul2_norm_round: directed FP32 cases, back-pressure, reset flush and
// randomized traffic checked against an arithmetic reference model.
module tb_mul2_norm_round;

    typedef struct {
        bit        sign;
        int        expo;
        bit [23:0] a;
        bit [23:0] b;
        int        rs;
        int        ls;
    } stim_t;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  sign_1;
    logic [9:0]  expo_1;
    logic [23:0] a_mant_f;
    logic [23:0] b_mant_f;
    logic [5:0]  r_shift;
    logic [5:0]  l_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   out_count = 0;
    bit   bp_rand = 1'b0;

    mul2_norm_round #(
        .SIGN_W(1),
        .EXPO_W(8),
        .MANT_W(23)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sign_1   (sign_1),
        .expo_1   (expo_1),
        .a_mant_f (a_mant_f),
        .b_mant_f (b_mant_f),
        .r_shift  (r_shift),
        .l_shift  (l_shift),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .ovf      (ovf),
        .unf      (unf),
        .inx      (inx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    // Reference: value-level rounding using remainder vs. half-ulp.
    function automatic exp_t model(input stim_t s);
        exp_t              r;
        longint unsigned   prod, p, rem, half, frac;
        longint            e;
        int                sh;
        bit                rsticky, up, inexact;
        r.res = {s.sign, 31'd0};
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.inx = 1'b0;
        prod = 64'(s.a) * 64'(s.b);
        if (prod == 0) return r;
        rsticky = 1'b0;
        if (s.rs != 0) begin
            rsticky = (prod & ((64'd1 << s.rs) - 1)) != 0;
            p = prod >> s.rs;
            e = 0;
        end else if (s.ls != 0) begin
            p = (prod << s.ls) & 64'h0000_FFFF_FFFF_FFFF;
            e = longint'(s.expo) - longint'(s.ls);
        end else begin
            p = prod;
            e = longint'(s.expo);
        end
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        if (sh == 24) e = e + 1;
        frac = (p >> sh) & 64'h7F_FFFF;
        rem  = p & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || (rem == half && frac[0]);
        frac = frac + 64'(up);
        if (frac == 64'h80_0000) begin
            frac = 0;
            e = e + 1;
        end
        inexact = (rem != 0) || rsticky;
        if (e >= 255) begin
            r.res = {s.sign, 8'hFF, 23'd0};
            r.ovf = 1'b1;
            r.inx = 1'b1;
        end else if (e <= 0) begin
            if (s.rs != 0) begin
                r.res = {s.sign, 8'h00, frac[22:0]};
                r.unf = inexact;
                r.inx = inexact;
            end else begin
                r.unf = 1'b1;
                r.inx = 1'b1;
            end
        end else begin
            r.res = {s.sign, e[7:0], frac[22:0]};
            r.inx = inexact;
        end
        return r;
    endfunction

    function automatic stim_t mk(input bit sg, input int ex, input bit [23:0] a,
                                 input bit [23:0] b, input int rs, input int ls);
        stim_t s;
        s.sign = sg;
        s.expo = ex;
        s.a    = a;
        s.b    = b;
        s.rs   = rs;
        s.ls   = ls;
        return s;
    endfunction

    function automatic exp_t mkexp(input logic [31:0] r, input logic o, input logic u,
                                   input logic i);
        exp_t e;
        e.res = r;
        e.ovf = o;
        e.unf = u;
        e.inx = i;
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.sign = 1'($urandom_range(0, 1));
        s.expo = int'($urandom_range(0, 340)) - 40;
        s.a    = 24'h80_0000 | 24'($urandom);
        s.b    = 24'h80_0000 | 24'($urandom);
        s.rs   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 26)) : 0;
        s.ls   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 0;
        if (s.ls != 0 && $urandom_range(0, 1) == 1) s.a = 24'($urandom_range(1, 24'h7F_FFFF));
        if ($urandom_range(0, 7) == 0) s.a = 24'hFF_FFFF;
        if ($urandom_range(0, 15) == 0) s.b = '0;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic apply(input stim_t s);
        sign_1   = s.sign;
        expo_1   = 10'(s.expo);
        a_mant_f = s.a;
        b_mant_f = s.b;
        r_shift  = 6'(s.rs);
        l_shift  = 6'(s.ls);
    endtask

    // Returns just after the accepting clock edge, in_valid still high.
    task automatic send(input stim_t s, input exp_t e);
        int guard;
        guard = 0;
        @(negedge clk);
        apply(s);
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=0, want 1");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            #3;
            guard++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                out_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got res=%h ovf=%b unf=%b inx=%b, want none",
                             res, ovf, unf, inx);
                end else begin
                    e = exp_q.pop_front();
                    if ({res, ovf, unf, inx} !== e) begin
                        n_bad++;
                        $display("FAIL result: got res=%h ovf=%b unf=%b inx=%b, want res=%h ovf=%b unf=%b inx=%b",
                                 res, ovf, unf, inx, e.res, e.ovf, e.unf, e.inx);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        stim_t sa, sb, sc;
        int    base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_flags", 32'({ovf, unf, inx}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1.5 * 1.5 with latency check
        send(mk(0, 127, 24'hC0_0000, 24'hC0_0000, 0, 0), mkexp(32'h4010_0000, 0, 0, 0));
        idle();
        #1;
        check("lat_p_stage", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_r_stage", 32'(out_valid), 32'd1);
        drain();

        send(mk(0, 127, 24'h80_0001, 24'hC0_0000, 0, 0), mkexp(32'h3FC0_0002, 0, 0, 1));
        send(mk(1, 300, 24'h80_0000, 24'h80_0000, 0, 0), mkexp(32'hFF80_0000, 1, 0, 1));
        send(mk(0, 0, 24'h80_0000, 24'h80_0000, 2, 0), mkexp(32'h0020_0000, 0, 0, 0));
        send(mk(1, 0, 24'h80_0000, 24'h80_0000, 0, 0), mkexp(32'h8000_0000, 0, 1, 1));
        send(mk(1, 400, 24'h00_0000, 24'hC0_0000, 0, 0), mkexp(32'h8000_0000, 0, 0, 0));
        idle();
        drain();

        // Back-pressure: two accepts fill both stages, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        sa = rand_stim();
        sb = rand_stim();
        sc = rand_stim();
        send(sa, model(sa));
        send(sb, model(sb));
        @(negedge clk);
        apply(sc);
        #1;
        check("bp_stall", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("bp_hold", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        base = out_count;
        #1;
        check("bp_release", 32'(in_ready), 32'd1);
        exp_q.push_back(model(sc));
        @(posedge clk);
        idle();
        @(negedge clk);
        #3;
        check("bp_count", 32'(out_count - base), 32'd3);
        drain();

        // Reset with both stages occupied flushes everything.
        @(negedge clk);
        out_ready = 1'b0;
        sa = rand_stim();
        sb = rand_stim();
        send(sa, model(sa));
        send(sb, model(sb));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_res", res, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("flush_quiet", 32'(out_valid), 32'd0);

        // Random traffic with random back-pressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sa = rand_stim();
            send(sa, model(sa));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        bp_rand = 1'b0;
        @(negedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
